// File: rtl/restoring_divider_8bit_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg: shared definitions for the restoring divider.
//   DIV_WIDTH    - default operand/quotient/remainder width
//   div_state_e  - FSM state encoding (IDLE/RUN/DONE)
//   div_cnt_w()  - iteration counter width for a given operand width
//   DIV_ALL_ONES - wide all-ones constant; sliced to WIDTH for the
//                  divide-by-zero quotient
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // clog2(WIDTH), floored at 1 so a degenerate WIDTH still gets a counter bit
    function automatic int div_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam logic [63:0] DIV_ALL_ONES = '1;

endpackage

// File: rtl/restoring_divider_8bit_if.sv
// ----------------------------------------------------------------------------
// restoring_divider_8bit_if: request/result bundle for the divider.
//   start, dividend, divisor : request (master -> slave)
//   busy, done, quotient,
//   remainder, div_by_zero   : status/result (slave -> master)
// ----------------------------------------------------------------------------
interface restoring_divider_8bit_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_8bit_div_step.sv
// ----------------------------------------------------------------------------
// div_step: one combinational restoring-division step.
//   r, q, d         : partial remainder, shifting dividend/quotient, divisor
//   r_next, q_next  : values after one trial subtraction
// The trial subtract is written as T + ~{0,D} + 1 over WIDTH+1 bits so this
// block can be replaced by the carry-lookahead adder stage unchanged.
// ----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d_inv;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           borrow;

    always_comb begin
        t     = {r, q[WIDTH-1]};
        d_inv = ~{1'b0, d};
        {carry, diff} = {1'b0, t} + {1'b0, d_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
        // diff[WIDTH] can only be set if T - D >= 2^WIDTH, which needs R >= D
        // on entry; treating it as a borrow keeps r_next bounded when the
        // step is driven standalone with out-of-range operands.
        borrow = ~carry | diff[WIDTH];
        r_next = borrow ? t[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/restoring_divider_8bit.sv
// ----------------------------------------------------------------------------
// restoring_divider_8bit: sequential unsigned divider, one quotient bit per
// clock using the restoring algorithm.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of restoring_divider_8bit_if
//                start/dividend/divisor sampled in IDLE only;
//                busy in RUN, done one-cycle pulse in DONE;
//                quotient/remainder/div_by_zero registered, held until the
//                next accepted start.
// Divisor 0 skips RUN: quotient = all ones, remainder = dividend.
// ----------------------------------------------------------------------------
module restoring_divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    restoring_divider_8bit_if.slave   bus
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;          // latched divisor
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out / quotient in
    logic [WIDTH-1:0] r_q, r_d;          // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r_next;
    logic [WIDTH-1:0] step_q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (step_r_next),
        .q_next (step_q_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = DIV_ALL_ONES[WIDTH-1:0];
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        d_d     = bus.divisor;
                        q_d     = bus.dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                q_d   = step_q_next;
                r_d   = step_r_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    quotient_d  = step_q_next;
                    remainder_d = step_r_next;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// ----------------------------------------------------------------------------
// tb_restoring_divider_8bit: directed vectors with hand-computed results for
// restoring_divider_8bit, plus a short random sweep against the
// division identity.
// ----------------------------------------------------------------------------
module tb_restoring_divider_8bit;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    restoring_divider_8bit_if #(.WIDTH(8)) bus ();

    restoring_divider_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one request for a single sampling edge; returns #1 after it.
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    // Counts edges until done is seen (bounded) and busy cycles on the way.
    task automatic wait_done(output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Full directed division with result, flag, latency and pulse-width checks.
    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                           input int elat, input int ebusy);
        int lat, bcyc;
        pulse_start(a, b);
        wait_done(lat, bcyc);
        chk({tag, "_lat"},  lat, elat);
        chk({tag, "_busy"}, bcyc, ebusy);
        chk({tag, "_q"},    bus.quotient, eq);
        chk({tag, "_r"},    bus.remainder, er);
        chk({tag, "_dbz"},  bus.div_by_zero, edbz);
        @(posedge clk); #1;
        chk({tag, "_done_w"}, bus.done, 1'b0);
    endtask

    initial begin
        int lat, bcyc, lat2;
        logic [7:0] a, b;
        n_chk        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_q",    bus.quotient, 8'd0);
        chk("rst_r",    bus.remainder, 8'd0);
        chk("rst_dbz",  bus.div_by_zero, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_vec("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8, 8);
        run_vec("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8, 8);
        run_vec("d5_200",   8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 8, 8);
        run_vec("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8, 8);
        run_vec("dbz37",    8'd37,  8'd0,   8'd255, 8'd37, 1'b1, 0, 0);
        // accepted start after a divide-by-zero clears the flag
        run_vec("d10_3",    8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 8, 8);

        // start re-pulsed during RUN is ignored
        pulse_start(8'd100, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        bus.start    = 1'b1;
        bus.dividend = 8'd10;
        bus.divisor  = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, bcyc);
        chk("ign_run_lat", lat + 4, 8);
        chk("ign_run_q",   bus.quotient, 8'd14);
        chk("ign_run_r",   bus.remainder, 8'd2);
        // start held from the done cycle: ignored there, accepted one later
        bus.start    = 1'b1;
        bus.dividend = 8'd10;
        bus.divisor  = 8'd3;
        @(posedge clk); #1;
        chk("ign_done_busy", bus.busy, 1'b0);
        chk("ign_done_done", bus.done, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1'b1);
        wait_done(lat, bcyc);
        chk("b2b_lat", lat, 8);
        chk("b2b_q",   bus.quotient, 8'd3);
        chk("b2b_r",   bus.remainder, 8'd1);

        // asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        pulse_start(8'd100, 8'd7);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_q",    bus.quotient, 8'd0);
        chk("arst_r",    bus.remainder, 8'd0);
        chk("arst_dbz",  bus.div_by_zero, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lat2 = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) lat2++;
        end
        chk("arst_no_done", lat2, 0);
        run_vec("d200_9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 8, 8);

        // random sweep against the division identity
        for (int i = 0; i < 1500; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            pulse_start(a, b);
            wait_done(lat, bcyc);
            if (32'(bus.quotient) * 32'(b) + 32'(bus.remainder) != 32'(a))
                chk("rnd_ident", {bus.quotient, bus.remainder}, {8'(a / b), 8'(a % b)});
            else
                chk("rnd_q", bus.quotient, 8'(a / b));
            chk("rnd_rlt", (bus.remainder < b), 1'b1);
            @(posedge clk); #1;
            chk("rnd_done_w", bus.done, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
